// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : serial_subtractor
//  Description : Bit-serial unsigned subtractor. Computes (a - b) one bit per
//                clock, LSB first, with one full-subtractor cell and a
//                registered borrow. Sequenced by a start/busy/done handshake;
//                diff and borrow are registered and held between operations.
//  Revision    : 1.0  initial release
// ============================================================================
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    // Bit counter needs to reach WIDTH-1; keep at least one bit for tiny widths.
    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q,  state_d;
    logic [WIDTH-1:0] ra_q,     ra_d;
    logic [WIDTH-1:0] rb_q,     rb_d;
    logic [WIDTH-1:0] rd_q,     rd_d;
    logic             br_q,     br_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;
    logic [WIDTH-1:0] diff_q,   diff_d;
    logic             borrow_q, borrow_d;

    // Full-subtractor cell acting on the current LSBs and the stored borrow.
    logic             w_x;
    logic             w_y;
    logic             w_d;
    logic             w_br_next;
    logic [WIDTH-1:0] w_rd_next;

    assign w_x       = ra_q[0];
    assign w_y       = rb_q[0];
    assign w_d       = w_x ^ w_y ^ br_q;
    assign w_br_next = (~w_x & w_y) | (~(w_x ^ w_y) & br_q);
    // New result bit enters at the MSB so that after WIDTH shifts bit 0 is at LSB.
    assign w_rd_next = {w_d, rd_q[WIDTH-1:1]};

    // Next-state and datapath computation for the IDLE/RUN/DONE sequencer.
    always_comb begin
        state_d  = state_q;
        ra_d     = ra_q;
        rb_d     = rb_q;
        rd_d     = rd_q;
        br_d     = br_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        diff_d   = diff_q;
        borrow_d = borrow_q;

        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    ra_d    = a;
                    rb_d    = b;
                    br_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = S_RUN;
                    busy_d  = 1'b1;
                end
            end
            S_RUN: begin
                ra_d = {1'b0, ra_q[WIDTH-1:1]};
                rb_d = {1'b0, rb_q[WIDTH-1:1]};
                rd_d = w_rd_next;
                br_d = w_br_next;
                if (cnt_q == C_LAST) begin
                    // Last bit: publish the result on the same edge; counter holds.
                    diff_d   = w_rd_next;
                    borrow_d = w_br_next;
                    state_d  = S_DONE;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                // start is ignored here; a new request must be seen in IDLE.
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset overrides any in-flight operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            ra_q     <= '0;
            rb_q     <= '0;
            rd_q     <= '0;
            br_q     <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ra_q     <= ra_d;
            rb_q     <= rb_d;
            rd_q     <= rd_d;
            br_q     <= br_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign diff   = diff_q;
    assign borrow = borrow_q;

endmodule
`default_nettype wire

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial unsigned subtractor: computes `a - b` one bit per clock, LSB first, using a single full-subtractor cell and a registered borrow. It pairs with the combinational adder cells as the inverse arithmetic path for SP605 bring-up. It is sequenced by a start/busy/done handshake and feeds result LEDs or a checker.

## Interface
Parameters:
- `WIDTH`, default 8: operand and result width in bits; legal range 2..32.

Ports:
- `clk`, in, 1: single clock; all logic is rising-edge.
- `rst`, in, 1: synchronous, active-high reset.
- `start`, in, 1: request; sampled only in IDLE.
- `a`, in, WIDTH: minuend; captured on the accepting edge.
- `b`, in, WIDTH: subtrahend; captured on the accepting edge.
- `busy`, out, 1: high while RUN.
- `done`, out, 1: one-cycle pulse when the result is valid.
- `diff`, out, WIDTH: `(a - b) mod 2^WIDTH`, registered and held.
- `borrow`, out, 1: final borrow out; 1 iff `a < b` unsigned. Registered and held.

## Operation
- FSM states:
  - IDLE: wait for `start`.
  - RUN: compute one bit per cycle.
  - DONE: single cycle, then return to IDLE.
- IDLE with `start=1`:
  - load shift registers `ra<=a`, `rb<=b`; clear internal borrow `br<=0`; clear bit counter `cnt<=0`.
  - go to RUN.
- Each RUN cycle, with `x=ra[0]`, `y=rb[0]`:
  - `d = x^y^br`
  - `br_next = (~x&y) | (~(x^y)&br)`
  - shift `ra`, `rb` right by one.
  - shift `d` into the MSB of internal result register `rd`.
  - `cnt<=cnt+1`.
- When `cnt==WIDTH-1` in RUN, the same edge:
  - loads `diff<=` the final `rd` including the current `d`, and `borrow<=br_next`.
  - goes to DONE.
- DONE: `done=1` for exactly one cycle, then IDLE.
- `start` in RUN or DONE is ignored; no queuing.
- `diff` and `borrow` change only on the edge entering DONE, or on reset. They hold between operations.
- Counter width is `$clog2(WIDTH)`, minimum 1 bit; no wrap beyond WIDTH-1.

## Timing
- Reset values: state IDLE, `busy=0`, `done=0`, `diff=0`, `borrow=0`, internal `ra/rb/rd/br/cnt=0`.
- `start` accepted at edge k:
  - `busy=1` from after edge k to after edge k+WIDTH.
  - edges k+1..k+WIDTH process bits 0..WIDTH-1.
  - after edge k+WIDTH: `done=1`, `busy=0`, `diff`/`borrow` valid.
  - after edge k+WIDTH+1: `done=0`, IDLE.
- Latency from accepting edge to `done`: WIDTH cycles.
- Earliest next accept is edge k+WIDTH+2. Throughput is one result per WIDTH+2 cycles.
- `busy` and `done` are never high together. `done` is never high for two consecutive cycles.
- Inputs `a`/`b` may change freely after the accepting edge without affecting the result.
- `rst` has priority over all other events:
  - `rst=1` at any edge, including mid-RUN or in DONE, forces reset values at that edge.
  - a partial result is discarded and no `done` is produced.
- `rst=1` and `start=1` on the same edge: reset wins and `start` is not accepted.

## Test plan
- WIDTH=8, `a=200`, `b=55`, start one cycle → `done` exactly 8 cycles after the accept; `diff=145`, `borrow=0`; `busy` high for 8 cycles.
- `a=5`, `b=10` → `diff=251`, `borrow=1`. Then `a=0`, `b=255` → `diff=1`, `borrow=1`. Then `a=b=170` → `diff=0`, `borrow=0`.
- Pulse `start` with new operands (`a=1`, `b=1`) in the 3rd RUN cycle of `200-55` → ignored; result still 145/0; only one `done` pulse.
- Assert `rst` in the 4th RUN cycle of `5-10` → next cycle `busy=0`, `done=0`, `diff=0`, `borrow=0`; no `done` follows. A fresh `start` with `9-4` gives `diff=5`, `borrow=0`.
- Hold `start=1` continuously with `a=100`, `b=1` → accepts every 10 cycles; each result is 99/0; `diff` is stable between `done` pulses.
- Random sweep of 1000 operand pairs at WIDTH=8 and WIDTH=16 against a reference model `{borrow,diff} = {1'b0,a} - {1'b0,b}` → zero mismatches.
